dwt_poly_gather: RTL and testbench



---
 rtl/dwt_poly_gather.sv | 118 +++++++++++
 tb/tb_dwt_poly_gather.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dwt_poly_gather.sv
// dwt_poly_gather
// Collects a serial stream of signed samples into blocks of six. For each
// block k it presents the nine-sample window x[6k-3] .. x[6k+5]. The six
// polyphase FIR branches downstream read this window in parallel.
//
// Optional build macro: DWT_GATHER_SYMEXT_EN
//   defined   - the first block after reset/sclr fills its history slots
//               with a whole-sample symmetric extension (x[3], x[2], x[1])
//   undefined - the first block uses zero history
//
// State table (state | meaning)
//   r_phase 0..5   | index of the next sample within the current block
//   r_out_valid    | a window is pending for the downstream stage
//   r_first        | the next window to load is block 0 since reset/sclr
module dwt_poly_gather #(
    parameter int w_in   = 7,
    parameter int N_PH   = 6,
    parameter int N_HIST = 3
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           sclr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [w_in-1:0]         in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [(N_PH+N_HIST)*w_in-1:0]  x_win,
    output logic                           out_first
);

    localparam int N_WIN = N_PH + N_HIST;

    logic        [2:0]            r_phase;
    logic signed [w_in-1:0]       r_buf  [N_PH];
    logic signed [w_in-1:0]       r_hist [N_HIST];
    logic [N_WIN*w_in-1:0]        r_win;
    logic                         r_out_valid;
    logic                         r_out_first;
    logic                         r_first;

    logic                         w_last;
    logic                         w_accept;
    logic [N_WIN*w_in-1:0]        w_win_next;

    // The sixth sample may only enter once the pending window can drain.
    assign w_last    = (r_phase == 3'(N_PH - 1));
    assign in_ready  = !(w_last && r_out_valid && !out_ready);
    assign w_accept  = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign x_win     = r_win;
    assign out_first = r_out_first;

    // Assemble the window that would load if this cycle's accept completes a block.
    always_comb begin
        w_win_next = '0;
        for (int j = 0; j < N_HIST; j++) begin
            if (r_first) begin
`ifdef DWT_GATHER_SYMEXT_EN
                // Mirror about x[0] without repeating it: slot j = x[N_HIST-j].
                w_win_next[j*w_in +: w_in] = r_buf[N_HIST - j];
`else
                w_win_next[j*w_in +: w_in] = '0;
`endif
            end else begin
                w_win_next[j*w_in +: w_in] = r_hist[j];
            end
        end
        for (int i = 0; i < N_PH - 1; i++) begin
            w_win_next[(N_HIST+i)*w_in +: w_in] = r_buf[i];
        end
        // The last sample is still on in_data; it is written to the buffer in the same edge.
        w_win_next[(N_WIN-1)*w_in +: w_in] = in_data;
    end

    // Phase counter, sample buffer, history and the registered output window.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase     <= '0;
            r_win       <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_first     <= 1'b1;
            for (int i = 0; i < N_PH; i++)   r_buf[i]  <= '0;
            for (int j = 0; j < N_HIST; j++) r_hist[j] <= '0;
        end else if (sclr) begin
            r_phase     <= '0;
            r_win       <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_first     <= 1'b1;
            for (int i = 0; i < N_PH; i++)   r_buf[i]  <= '0;
            for (int j = 0; j < N_HIST; j++) r_hist[j] <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_buf[r_phase] <= in_data;
                if (w_last) begin
                    r_phase     <= '0;
                    r_win       <= w_win_next;
                    r_out_valid <= 1'b1;
                    r_out_first <= r_first;
                    r_first     <= 1'b0;
                    // The newest N_HIST samples of this block become the next history.
                    for (int j = 0; j < N_HIST; j++) begin
                        r_hist[j] <= w_win_next[(N_PH+j)*w_in +: w_in];
                    end
                end else begin
                    r_phase <= r_phase + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dwt_poly_gather.sv
// Testbench for dwt_poly_gather: a table of blocks streamed with out_ready
// held high, plus hand-written sequences for backpressure, simultaneous
// drain/load, sclr on a partial block and asynchronous reset mid-block.
module tb_dwt_poly_gather;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sclr;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [62:0] x_win;
    logic        out_first;

    int n_chk = 0;
    int n_err = 0;
    int n_hs  = 0;

    always #5 clk = ~clk;

    dwt_poly_gather dut (
        .clk       (clk),
        .rstn      (rstn),
        .sclr      (sclr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_win     (x_win),
        .out_first (out_first)
    );

    // Count window handshakes away from the active edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) n_hs++;
    end

    typedef struct {
        logic clr;
        logic first;
        int   s[6];
        int   h[3];
    } blk_t;

    blk_t tbl[5];

    task automatic chk(input string nm, input logic [62:0] act, input logic [62:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        in_data  = v[6:0];
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [62:0] pk(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7, input int a8);
        return {a8[6:0], a7[6:0], a6[6:0], a5[6:0], a4[6:0],
                a3[6:0], a2[6:0], a1[6:0], a0[6:0]};
    endfunction

    // Expected window for a block whose six samples are s0..s5.
    function automatic logic [62:0] win_of(input logic first, input int h0, input int h1,
                                           input int h2, input int s0, input int s1,
                                           input int s2, input int s3, input int s4,
                                           input int s5);
        if (first) begin
`ifdef DWT_GATHER_SYMEXT_EN
            return pk(s3, s2, s1, s0, s1, s2, s3, s4, s5);
`else
            return pk(0, 0, 0, s0, s1, s2, s3, s4, s5);
`endif
        end
        return pk(h0, h1, h2, s0, s1, s2, s3, s4, s5);
    endfunction

    logic [62:0] exp_w;
    logic [62:0] w0;
    int          base;

    initial begin
        tbl[0] = '{clr: 1'b0, first: 1'b1, s: '{1, 2, 3, 4, 5, 6},        h: '{0, 0, 0}};
        tbl[1] = '{clr: 1'b0, first: 1'b0, s: '{7, 8, 9, 10, 11, 12},     h: '{4, 5, 6}};
        tbl[2] = '{clr: 1'b0, first: 1'b0, s: '{13, 14, 15, 16, 17, 18},  h: '{10, 11, 12}};
        tbl[3] = '{clr: 1'b1, first: 1'b1, s: '{-64, 63, -1, 0, -2, 5},   h: '{0, 0, 0}};
        tbl[4] = '{clr: 1'b0, first: 1'b0, s: '{1, 2, 3, 4, 5, 6},        h: '{0, -2, 5}};

        rstn      = 1'b0;
        sclr      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 63'(out_valid), 63'd0);
        chk("rst_x_win",     x_win,          63'd0);
        chk("rst_out_first", 63'(out_first), 63'd0);
        chk("rst_in_ready",  63'(in_ready),  63'd1);
        rstn = 1'b1;
        step();

        // Block table, out_ready held high.
        for (int b = 0; b < 5; b++) begin
            if (tbl[b].clr) begin
                sclr = 1'b1;
                step();
                sclr = 1'b0;
                chk("tbl_sclr_ov", 63'(out_valid), 63'd0);
            end
            for (int i = 0; i < 6; i++) begin
                send(tbl[b].s[i]);
                if (i == 4) chk("tbl_pre_ov", 63'(out_valid), 63'd0);
            end
            exp_w = win_of(tbl[b].first, tbl[b].h[0], tbl[b].h[1], tbl[b].h[2],
                           tbl[b].s[0], tbl[b].s[1], tbl[b].s[2],
                           tbl[b].s[3], tbl[b].s[4], tbl[b].s[5]);
            chk("tbl_out_valid", 63'(out_valid), 63'd1);
            chk("tbl_x_win",     x_win,          exp_w);
            chk("tbl_out_first", 63'(out_first), 63'(tbl[b].first));
        end
        step();
        chk("tbl_drain_ov", 63'(out_valid), 63'd0);

        // Backpressure, then drain and 6th accept in the same edge.
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        base = n_hs;
        for (int i = 1; i <= 6; i++) send(i);
        w0 = win_of(1'b1, 0, 0, 0, 1, 2, 3, 4, 5, 6);
        chk("bp_w0", x_win, w0);
        chk("bp_w0_first", 63'(out_first), 63'd1);
        out_ready = 1'b0;
        for (int i = 7; i <= 11; i++) begin
            #1;
            chk("bp_in_ready_hi", 63'(in_ready), 63'd1);
            send(i);
        end
        in_valid = 1'b1;
        in_data  = 7'd12;
        #1;
        chk("bp_in_ready_lo", 63'(in_ready), 63'd0);
        step();
        step();
        chk("bp_hold_ov",    63'(out_valid), 63'd1);
        chk("bp_hold_win",   x_win,          w0);
        chk("bp_hold_first", 63'(out_first), 63'd1);
        chk("bp_hold_ready", 63'(in_ready),  63'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 63'(in_ready), 63'd1);
        step();
        in_valid = 1'b0;
        chk("bp_w1_ov",    63'(out_valid), 63'd1);
        chk("bp_w1",       x_win,          pk(4, 5, 6, 7, 8, 9, 10, 11, 12));
        chk("bp_w1_first", 63'(out_first), 63'd0);
        step();
        chk("bp_drain_ov", 63'(out_valid), 63'd0);
        chk("bp_hs_count", 63'(n_hs - base), 63'd2);

        // sclr on a partial block; data presented during sclr is dropped.
        for (int i = 31; i <= 34; i++) send(i);
        sclr     = 1'b1;
        in_valid = 1'b1;
        in_data  = 7'd99;
        step();
        sclr     = 1'b0;
        in_valid = 1'b0;
        chk("sclr_ov",    63'(out_valid), 63'd0);
        chk("sclr_x_win", x_win,          63'd0);
        chk("sclr_first", 63'(out_first), 63'd0);
        for (int i = 21; i <= 26; i++) send(i);
        chk("sclr_win",       x_win,          win_of(1'b1, 0, 0, 0, 21, 22, 23, 24, 25, 26));
        chk("sclr_win_first", 63'(out_first), 63'd1);
        step();

        // Asynchronous reset in the middle of a block.
        for (int i = 1; i <= 3; i++) send(40 + i);
        rstn = 1'b0;
        #2;
        chk("arst_ov",       63'(out_valid), 63'd0);
        chk("arst_x_win",    x_win,          63'd0);
        chk("arst_first",    63'(out_first), 63'd0);
        chk("arst_in_ready", 63'(in_ready),  63'd1);
        #2;
        rstn = 1'b1;
        for (int i = 1; i <= 6; i++) send(i);
        chk("arst_win",       x_win,          win_of(1'b1, 0, 0, 0, 1, 2, 3, 4, 5, 6));
        chk("arst_win_first", 63'(out_first), 63'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
